// File: rtl/toggle_cover_pkg.sv
// Shared parameters and helpers for the toggle-coverage collector.
// The popcount helper works on the maximum supported width; callers zero-extend.
package toggle_cover_pkg;

    localparam int unsigned IDX_W_DEF = 32;
    localparam int unsigned MAX_WIDTH = 4096;
    localparam int unsigned MAX_CNT_W = 13;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_WIDTH-1:0] vec);
        logic [MAX_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + MAX_CNT_W'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/toggle_cover_prio_enc.sv
// Lowest-set-bit priority encoder with an any-set flag (combinational).
module toggle_cover_prio_enc
    import toggle_cover_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SEL_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/toggle_cover_collector.sv
// Sticky toggle-coverage collector: latches first hits and reports each newly
// covered point exactly once as a global index over a valid/ready stream.
module toggle_cover_collector
    import toggle_cover_pkg::*;
#(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = 8744,
    parameter int unsigned IDX_W       = IDX_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          valid,
    input  logic                      enable,
    input  logic                      clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_index,
    output logic [cnt_w(WIDTH)-1:0]   hit_count,
    output logic                      all_hit
);

    localparam int unsigned CNT_W = cnt_w(WIDTH);
    localparam int unsigned SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("toggle_cover_collector: WIDTH must be within 1..4096");
    end
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
        $error("toggle_cover_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] pending;

    logic [WIDTH-1:0] new_bits;
    logic [WIDTH-1:0] hit_nxt;
    logic [WIDTH-1:0] pending_nxt;
    logic [CNT_W-1:0] hit_count_nxt;
    logic             all_hit_nxt;
    logic             out_valid_nxt;
    logic [IDX_W-1:0] out_index_nxt;

    logic [SEL_W-1:0] sel;
    logic             sel_any;
    logic             slot_free;

    toggle_cover_prio_enc #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_prio_enc (
        .vec (pending),
        .idx (sel),
        .any (sel_any)
    );

    assign new_bits  = valid & ~hit & {WIDTH{enable}};
    assign slot_free = ~out_valid | out_ready;

    // Next-state: sticky hits, pending queue and the report slot.
    always_comb begin
        hit_nxt       = hit | new_bits;
        pending_nxt   = pending | new_bits;
        hit_count_nxt = hit_count + CNT_W'(popcount(MAX_WIDTH'(new_bits)));
        all_hit_nxt   = (hit_count_nxt == CNT_W'(WIDTH));
        out_valid_nxt = out_valid;
        out_index_nxt = out_index;

        if (slot_free) begin
            if (sel_any) begin
                // sel is already hit, so new_bits cannot re-set it this cycle.
                pending_nxt[sel] = 1'b0;
                out_valid_nxt    = 1'b1;
                out_index_nxt    = IDX_W'(COVER_INDEX) + IDX_W'(sel);
            end else begin
                out_valid_nxt = 1'b0;
            end
        end

        if (clear) begin
            hit_nxt       = '0;
            pending_nxt   = '0;
            hit_count_nxt = '0;
            all_hit_nxt   = 1'b0;
            out_valid_nxt = 1'b0;
            out_index_nxt = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit       <= '0;
            pending   <= '0;
            hit_count <= '0;
            all_hit   <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
        end else begin
            hit       <= hit_nxt;
            pending   <= pending_nxt;
            hit_count <= hit_count_nxt;
            all_hit   <= all_hit_nxt;
            out_valid <= out_valid_nxt;
            out_index <= out_index_nxt;
        end
    end

`ifndef SYNTHESIS
    // A stalled report must stay put until accepted or cleared.
    a_hold_stable: assert property (
        @(posedge clock) disable iff (!reset)
        (out_valid && !out_ready && !clear) |=> (out_valid && $stable(out_index))
    );
`endif

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector (WIDTH=8, COVER_INDEX=100).
module tb_toggle_cover_collector;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned BASE  = 100;

    logic        clock;
    logic        reset;
    logic [7:0]  valid;
    logic        enable;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_index;
    logic [3:0]  hit_count;
    logic        all_hit;

    int n_checks = 0;
    int n_fail   = 0;

    toggle_cover_collector #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (BASE),
        .COVER_TOTAL (8744),
        .IDX_W       (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .valid     (valid),
        .enable    (enable),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .hit_count (hit_count),
        .all_hit   (all_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic int pop8(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    logic [7:0] exp_hit;
    logic [7:0] seen;
    int         n_reports;
    int         b;

    initial begin
        reset     = 1'b0;
        valid     = '0;
        enable    = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_index", out_index, 0);
        check("rst_hit_count", 32'(hit_count), 0);
        check("rst_all_hit", 32'(all_hit), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single hit: count in c+1, report in c+2, repeat ignored.
        valid = 8'h01;
        tick();
        valid = '0;
        check("lat_count_c1", 32'(hit_count), 1);
        check("lat_valid_c1", 32'(out_valid), 0);
        tick();
        check("lat_valid_c2", 32'(out_valid), 1);
        check("lat_index_c2", out_index, 100);
        tick();
        check("lat_drained", 32'(out_valid), 0);
        valid = 8'h01;
        tick();
        valid = '0;
        tick();
        tick();
        check("repeat_no_report", 32'(out_valid), 0);
        check("repeat_count", 32'(hit_count), 1);

        // Multiple same-cycle hits report in ascending order back to back.
        do_clear();
        valid = 8'hA5;
        tick();
        valid = '0;
        check("a5_count", 32'(hit_count), 4);
        tick();
        check("a5_idx0", out_index, 100);
        tick();
        check("a5_idx1", out_index, 102);
        tick();
        check("a5_idx2", out_index, 105);
        tick();
        check("a5_idx3", out_index, 107);
        check("a5_valid3", 32'(out_valid), 1);
        tick();
        check("a5_drained", 32'(out_valid), 0);

        // Back-pressure: slot holds index 100 while stalled, then drains.
        do_clear();
        out_ready = 1'b0;
        valid = 8'hFF;
        tick();
        valid = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 1);
            check("stall_index", out_index, 100);
        end
        check("stall_all_hit", 32'(all_hit), 1);
        check("stall_count", 32'(hit_count), 8);
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            check("drain_index", out_index, 32'(100 + i));
        end
        tick();
        check("drain_done", 32'(out_valid), 0);

        // Enable low ignores events; clear beats same-cycle events.
        do_clear();
        enable = 1'b0;
        valid = 8'hFF;
        tick();
        enable = 1'b1;
        valid = '0;
        tick();
        check("dis_count", 32'(hit_count), 0);
        check("dis_valid", 32'(out_valid), 0);
        valid = 8'h0F;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        valid = '0;
        check("clr_prio_count", 32'(hit_count), 0);
        check("clr_prio_all_hit", 32'(all_hit), 0);
        tick();
        tick();
        check("clr_prio_valid", 32'(out_valid), 0);

        // Clear drops an in-flight report and all pending bits.
        out_ready = 1'b0;
        valid = 8'h03;
        tick();
        valid = '0;
        tick();
        check("inflight_valid", 32'(out_valid), 1);
        do_clear();
        check("inflight_dropped", 32'(out_valid), 0);
        out_ready = 1'b1;
        tick();
        tick();
        check("inflight_no_pending", 32'(out_valid), 0);
        check("inflight_count", 32'(hit_count), 0);

        // Asynchronous reset mid-drain, between clock edges.
        valid = 8'hFF;
        tick();
        valid = '0;
        tick();
        tick();
        check("pre_rst_index", out_index, 101);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_count", 32'(hit_count), 0);
        check("async_rst_all_hit", 32'(all_hit), 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        valid = 8'h08;
        tick();
        valid = '0;
        check("rehit_count", 32'(hit_count), 1);
        tick();
        check("rehit_valid", 32'(out_valid), 1);
        check("rehit_index", out_index, 103);
        tick();
        check("rehit_drained", 32'(out_valid), 0);

        // Random sparse events and random back-pressure against a sticky-set model.
        do_clear();
        exp_hit   = '0;
        seen      = '0;
        n_reports = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            valid     = '0;
            if ($urandom_range(0, 9) == 0) valid[$urandom_range(0, 7)] = 1'b1;
            exp_hit |= valid;
            if (out_valid && out_ready) begin
                b = int'(out_index) - int'(BASE);
                check("rand_range", 32'(b >= 0 && b < 8), 1);
                if (b >= 0 && b < 8) begin
                    check("rand_dup", 32'(seen[b]), 0);
                    seen[b] = 1'b1;
                end
                n_reports++;
            end
            tick();
        end
        valid     = '0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid && out_ready) begin
                b = int'(out_index) - int'(BASE);
                check("drain_range", 32'(b >= 0 && b < 8), 1);
                if (b >= 0 && b < 8) begin
                    check("drain_dup", 32'(seen[b]), 0);
                    seen[b] = 1'b1;
                end
                n_reports++;
            end
            tick();
        end
        check("rand_all_reported", 32'(seen), 32'(exp_hit));
        check("rand_report_count", 32'(n_reports), 32'(pop8(exp_hit)));
        check("rand_hit_count", 32'(hit_count), 32'(pop8(exp_hit)));
        check("rand_all_hit", 32'(all_hit), 32'(exp_hit == 8'hFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
